// File: rtl/session_pkg.sv
// Shared state type, default penalty value and score clamp helper for the
// reaction-timer trial session controller.
package session_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_GAP,
        S_DONE
    } sess_state_t;

    localparam int unsigned DEFAULT_MAX_MS = 1000;

    function automatic int unsigned clamp_ms(input int unsigned ms, input int unsigned max_ms);
        return (ms > max_ms) ? max_ms : ms;
    endfunction

endpackage

// File: rtl/trial_session_ctrl_if.sv
// Handshake between the session controller (master) and the reaction-timer core (slave).
interface trial_session_ctrl_if #(
    parameter int unsigned MS_W = 11
);
    logic            trial_arm;
    logic            trial_done;
    logic [MS_W-1:0] trial_ms;
    logic            trial_early;

    modport master (output trial_arm, input trial_done, trial_ms, trial_early);
    modport slave  (input trial_arm, output trial_done, trial_ms, trial_early);
endinterface

// File: rtl/session_accum.sv
// Session statistics: best time, running sum and early count, with clear/score strobes.
// SESSION_RECORD_EN adds an all-time record that only rst clears.
module session_accum
    import session_pkg::*;
#(
    parameter int unsigned TRIALS_LOG2 = 2,
    parameter int unsigned MS_W        = 11,
    parameter int unsigned MAX_MS      = DEFAULT_MAX_MS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        score,
    input  logic                        score_early,
    input  logic [MS_W-1:0]             score_ms,
    output logic [MS_W-1:0]             best_ms,
    output logic [MS_W+TRIALS_LOG2-1:0] sum_ms,
    output logic [TRIALS_LOG2:0]        early_cnt
`ifdef SESSION_RECORD_EN
    ,
    output logic [MS_W-1:0]             record_ms,
    output logic                        new_record
`endif
);
    localparam int unsigned SUM_W = MS_W + TRIALS_LOG2;
    localparam int unsigned EW    = TRIALS_LOG2 + 1;
    localparam logic [MS_W-1:0] MAX_V = MS_W'(MAX_MS);

    logic [MS_W-1:0] points;

    // Early and timed-out trials carry the full penalty.
    always_comb begin
        points = score_early ? MAX_V : MS_W'(clamp_ms(32'(score_ms), MAX_MS));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            best_ms   <= MAX_V;
            sum_ms    <= '0;
            early_cnt <= '0;
        end else if (score) begin
            sum_ms <= sum_ms + SUM_W'(points);
            if (score_early) begin
                early_cnt <= early_cnt + EW'(1);
            end else if (points < best_ms) begin
                best_ms <= points;
            end
        end
    end

`ifdef SESSION_RECORD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            record_ms  <= MAX_V;
            new_record <= 1'b0;
        end else begin
            new_record <= 1'b0;
            if (score && !score_early && (points < record_ms)) begin
                record_ms  <= points;
                new_record <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/trial_session_ctrl.sv
// Sequences the reaction-timer core through 2**TRIALS_LOG2 trials with watchdog and gap.
// SESSION_RECORD_EN adds record_ms/new_record outputs for an all-time best.
module trial_session_ctrl
    import session_pkg::*;
#(
    parameter int unsigned TRIALS_LOG2 = 2,
    parameter int unsigned MS_W        = 11,
    parameter int unsigned MAX_MS      = DEFAULT_MAX_MS,
    parameter int unsigned GAP_MS      = 1500,
    parameter int unsigned TIMEOUT_MS  = 20000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ms_tick,
    input  logic                   start_p,
    input  logic                   clr_p,
    trial_session_ctrl_if.master   core,
    output logic                   busy,
    output logic [TRIALS_LOG2-1:0] trial_idx,
    output logic [MS_W-1:0]        best_ms,
    output logic [MS_W-1:0]        avg_ms,
    output logic [TRIALS_LOG2:0]   early_cnt,
    output logic                   result_valid
`ifdef SESSION_RECORD_EN
    ,
    output logic [MS_W-1:0]        record_ms,
    output logic                   new_record
`endif
);
    localparam int unsigned SUM_W = MS_W + TRIALS_LOG2;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_MS + 1);
    localparam int unsigned GAP_W = $clog2(GAP_MS + 1);
    localparam logic [TRIALS_LOG2-1:0] LAST_IDX = '1;

    sess_state_t      state;
    logic [WD_W-1:0]  wd_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [SUM_W-1:0] sum_ms;
    logic             start_ok;
    logic             timeout;
    logic             score;
    logic             score_early;
    logic             clear;
    logic             gap_end;

    always_comb begin
        start_ok    = start_p && ((state == S_IDLE) || (state == S_DONE));
        timeout     = (state == S_RUN) && ms_tick && (wd_cnt == WD_W'(TIMEOUT_MS - 1));
        // A done arriving with the expiring tick is scored normally.
        score       = !clr_p && (state == S_RUN) && (core.trial_done || timeout);
        score_early = !core.trial_done || core.trial_early;
        clear       = clr_p || start_ok;
        gap_end     = (state == S_GAP) && ms_tick && (gap_cnt == GAP_W'(GAP_MS - 1));
    end

    session_accum #(
        .TRIALS_LOG2 (TRIALS_LOG2),
        .MS_W        (MS_W),
        .MAX_MS      (MAX_MS)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .score       (score),
        .score_early (score_early),
        .score_ms    (core.trial_ms),
        .best_ms     (best_ms),
        .sum_ms      (sum_ms),
        .early_cnt   (early_cnt)
`ifdef SESSION_RECORD_EN
        ,
        .record_ms   (record_ms),
        .new_record  (new_record)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst || clr_p) begin
            state          <= S_IDLE;
            core.trial_arm <= 1'b0;
            busy           <= 1'b0;
            trial_idx      <= '0;
            avg_ms         <= '0;
            result_valid   <= 1'b0;
            wd_cnt         <= '0;
            gap_cnt        <= '0;
        end else begin
            core.trial_arm <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_p) begin
                        state          <= S_ARM;
                        core.trial_arm <= 1'b1;
                        busy           <= 1'b1;
                        result_valid   <= 1'b0;
                        trial_idx      <= '0;
                    end
                end
                S_ARM: begin
                    state  <= S_RUN;
                    wd_cnt <= '0;
                end
                S_RUN: begin
                    if (score) begin
                        state   <= S_GAP;
                        gap_cnt <= '0;
                    end else if (ms_tick) begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        if (trial_idx == LAST_IDX) begin
                            state        <= S_DONE;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                            avg_ms       <= MS_W'(sum_ms >> TRIALS_LOG2);
                        end else begin
                            state          <= S_ARM;
                            core.trial_arm <= 1'b1;
                            trial_idx      <= trial_idx + TRIALS_LOG2'(1);
                        end
                    end else if (ms_tick) begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
